// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Multi-byte instruction fetcher. It reads the opcode byte at
//               the PC, asks the external length decoder for the instruction
//               length, reads 0-2 operand bytes and presents the assembled
//               instruction to the control unit with a valid/ack handshake.
//               It owns the PC and advances it modulo 2^ADDR_WIDTH.
// Ports       : clk, reset (async, active-low)
//               start_i, pc_load_i, pc_load_val_i  - fetch request / jump
//               mem_addr_o, mem_rd_o, mem_rdata_i  - synchronous memory port
//               instr_len_i                        - decoded length of opcode_o
//               opcode_o, operand_o, instr_pc_o    - assembled instruction
//               pc_o, valid_o, ack_i, busy_o       - status / handshake
//               len_err_o                          - sticky length-0 error
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  pc_load_i,
    input  logic [ADDR_WIDTH-1:0] pc_load_val_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic [1:0]            instr_len_i,
    output logic [DATA_WIDTH-1:0] opcode_o,
    output logic [15:0]           operand_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  len_err_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_OP_REQ  = 4'd1,
        S_OP_LAT  = 4'd2,
        S_CHK_LEN = 4'd3,
        S_B2_REQ  = 4'd4,
        S_B2_LAT  = 4'd5,
        S_B3_REQ  = 4'd6,
        S_B3_LAT  = 4'd7,
        S_READY   = 4'd8
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0] opcode_q,   opcode_d;
    logic [15:0]           operand_q,  operand_d;
    logic [1:0]            len_q,      len_d;
    logic                  len_err_q,  len_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VECTOR;
            instr_pc_q <= '0;
            opcode_q   <= '0;
            operand_q  <= '0;
            len_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            len_q      <= len_d;
            len_err_q  <= len_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        len_d      = len_q;
        len_err_d  = len_err_q;

        unique case (state_q)
            S_IDLE: begin
                // A jump and a start in the same cycle fetch from the target.
                if (pc_load_i) begin
                    pc_d = pc_load_val_i;
                end
                if (start_i) begin
                    state_d    = S_OP_REQ;
                    operand_d  = '0;
                    instr_pc_d = pc_load_i ? pc_load_val_i : pc_q;
                end
            end
            S_OP_REQ: state_d = S_OP_LAT;
            S_OP_LAT: begin
                opcode_d = mem_rdata_i;
                pc_d     = pc_q + PC_ONE;
                state_d  = S_CHK_LEN;
            end
            S_CHK_LEN: begin
                // Length is latched here because instr_len_i follows
                // opcode_o combinationally and is only trusted now.
                len_d = instr_len_i;
                unique case (instr_len_i)
                    2'd0: begin
                        len_err_d = 1'b1;
                        state_d   = S_READY;
                    end
                    2'd1:    state_d = S_READY;
                    default: state_d = S_B2_REQ;
                endcase
            end
            S_B2_REQ: state_d = S_B2_LAT;
            S_B2_LAT: begin
                operand_d[7:0] = mem_rdata_i[7:0];
                pc_d           = pc_q + PC_ONE;
                state_d        = (len_q == 2'd3) ? S_B3_REQ : S_READY;
            end
            S_B3_REQ: state_d = S_B3_LAT;
            S_B3_LAT: begin
                operand_d[15:8] = mem_rdata_i[7:0];
                pc_d            = pc_q + PC_ONE;
                state_d         = S_READY;
            end
            S_READY: begin
                if (ack_i) begin
                    if (start_i) begin
                        state_d    = S_OP_REQ;
                        operand_d  = '0;
                        instr_pc_d = pc_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr_o = pc_q;
    assign mem_rd_o   = (state_q == S_OP_REQ) || (state_q == S_B2_REQ) ||
                        (state_q == S_B3_REQ);
    assign opcode_o   = opcode_q;
    assign operand_o  = operand_q;
    assign instr_pc_o = instr_pc_q;
    assign pc_o       = pc_q;
    assign valid_o    = (state_q == S_READY);
    assign busy_o     = (state_q != S_IDLE);
    assign len_err_o  = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A synchronous
//               byte memory and an opcode length table surround the DUT;
//               a vector table drives single fetches, and hand-written
//               sequences cover hold, back-to-back and mid-fetch reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic        pc_load_i;
    logic [15:0] pc_load_val_i;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_rdata_i;
    logic [1:0]  instr_len_i;
    logic [7:0]  opcode_o;
    logic [15:0] operand_o;
    logic [15:0] instr_pc_o;
    logic [15:0] pc_o;
    logic        valid_o;
    logic        ack_i;
    logic        busy_o;
    logic        len_err_o;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .pc_load_i     (pc_load_i),
        .pc_load_val_i (pc_load_val_i),
        .mem_addr_o    (mem_addr_o),
        .mem_rd_o      (mem_rd_o),
        .mem_rdata_i   (mem_rdata_i),
        .instr_len_i   (instr_len_i),
        .opcode_o      (opcode_o),
        .operand_o     (operand_o),
        .instr_pc_o    (instr_pc_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ack_i         (ack_i),
        .busy_o        (busy_o),
        .len_err_o     (len_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the read strobe.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
    end

    // Length decoder model.
    always_comb begin
        case (opcode_o)
            8'hA1:   instr_len_i = 2'd1;
            8'h3C:   instr_len_i = 2'd3;
            8'h50:   instr_len_i = 2'd2;
            8'hFF:   instr_len_i = 2'd0;
            default: instr_len_i = 2'd1;
        endcase
    end

    typedef struct {
        logic        load;
        logic [15:0] load_val;
        logic        glitch;    // pulse pc_load_i during OP_REQ
        logic [7:0]  op;
        logic [15:0] operand;
        logic [15:0] ipc;
        logic [15:0] pc;
        int          lat;
        int          rd;
        logic        err;
    } vec_t;

    vec_t vecs [4];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that accepted the fetch request.
    task automatic wait_and_check(input vec_t v, input string tag);
        int lat;
        int rd;
        pc_load_i     = v.glitch;
        pc_load_val_i = 16'h1234;
        rd  = mem_rd_o ? 1 : 0;
        lat = 0;
        while (!valid_o && lat < 20) begin
            tick();
            pc_load_i = 1'b0;
            lat++;
            rd += mem_rd_o ? 1 : 0;
        end
        pc_load_i = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " valid"},   64'(valid_o), 64'(1));
        check({tag, " opcode"},  64'(opcode_o), 64'(v.op));
        check({tag, " operand"}, 64'(operand_o), 64'(v.operand));
        check({tag, " instr_pc"}, 64'(instr_pc_o), 64'(v.ipc));
        check({tag, " pc"},      64'(pc_o), 64'(v.pc));
        check({tag, " rd_count"}, 64'(rd), 64'(v.rd));
        check({tag, " len_err"}, 64'(len_err_o), 64'(v.err));
    endtask

    task automatic ack_to_idle(input string tag);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check({tag, " valid after ack"}, 64'(valid_o), 64'(0));
        check({tag, " busy after ack"},  64'(busy_o), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " valid"},    64'(valid_o), 64'(0));
        check({tag, " busy"},     64'(busy_o), 64'(0));
        check({tag, " mem_rd"},   64'(mem_rd_o), 64'(0));
        check({tag, " len_err"},  64'(len_err_o), 64'(0));
        check({tag, " pc"},       64'(pc_o), 64'hF000);
        check({tag, " mem_addr"}, 64'(mem_addr_o), 64'hF000);
        check({tag, " opcode"},   64'(opcode_o), 64'(0));
        check({tag, " operand"},  64'(operand_o), 64'(0));
        check({tag, " instr_pc"}, 64'(instr_pc_o), 64'(0));
    endtask

    initial begin : main
        logic [63:0] snap;
        vec_t        v;
        logic        rose;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hF000] = 8'hA1;
        mem[16'hF001] = 8'h3C; mem[16'hF002] = 8'h34; mem[16'hF003] = 8'h12;
        mem[16'hFFFF] = 8'h50; mem[16'h0000] = 8'h7E;
        mem[16'h0001] = 8'hFF;
        mem[16'h0002] = 8'hA1;
        mem[16'h0003] = 8'h50; mem[16'h0004] = 8'hAA;
        mem[16'h0005] = 8'h3C; mem[16'h0006] = 8'hCD; mem[16'h0007] = 8'hAB;

        //          load  load_val  glitch op     operand   ipc       pc        lat rd err
        vecs[0] = '{1'b0, 16'h0000, 1'b0, 8'hA1, 16'h0000, 16'hF000, 16'hF001, 3, 1, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 8'h3C, 16'h1234, 16'hF001, 16'hF004, 7, 3, 1'b0};
        vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 8'h50, 16'h007E, 16'hFFFF, 16'h0001, 5, 2, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 8'hFF, 16'h0000, 16'h0001, 16'h0002, 3, 1, 1'b1};

        reset = 1'b0; start_i = 1'b0; pc_load_i = 1'b0; pc_load_val_i = '0; ack_i = 1'b0;
        #12;
        check_reset_values("reset");
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            pc_load_i     = vecs[i].load;
            pc_load_val_i = vecs[i].load_val;
            start_i       = 1'b1;
            tick();
            start_i   = 1'b0;
            pc_load_i = 1'b0;
            wait_and_check(vecs[i], $sformatf("vec%0d", i));
            ack_to_idle($sformatf("vec%0d", i));
        end

        // Hold in READY with ack low, then two back-to-back fetches.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        v = '{1'b0, 16'h0, 1'b0, 8'hA1, 16'h0000, 16'h0002, 16'h0003, 3, 1, 1'b1};
        wait_and_check(v, "hold_a1");
        snap = {7'd0, valid_o, opcode_o, operand_o, instr_pc_o, pc_o};
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold cyc%0d", i),
                  {7'd0, valid_o, opcode_o, operand_o, instr_pc_o, pc_o}, snap);
        end
        ack_i = 1'b1; start_i = 1'b1;
        tick();
        ack_i = 1'b0; start_i = 1'b0;
        check("b2b1 busy", 64'(busy_o), 64'(1));
        check("b2b1 mem_rd", 64'(mem_rd_o), 64'(1));
        v = '{1'b0, 16'h0, 1'b0, 8'h50, 16'h00AA, 16'h0003, 16'h0005, 5, 2, 1'b1};
        wait_and_check(v, "b2b_50");
        ack_i = 1'b1; start_i = 1'b1;
        tick();
        ack_i = 1'b0; start_i = 1'b0;
        check("b2b2 busy", 64'(busy_o), 64'(1));
        v = '{1'b0, 16'h0, 1'b0, 8'h3C, 16'hABCD, 16'h0005, 16'h0008, 7, 3, 1'b1};
        wait_and_check(v, "b2b_3c");
        ack_to_idle("b2b");

        // Reset during B2_LAT of a 3-byte fetch at F001.
        pc_load_i = 1'b1; pc_load_val_i = 16'hF001; start_i = 1'b1;
        tick();
        pc_load_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre-reset mem_rd in B2_LAT", 64'(mem_rd_o), 64'(0));
        check("pre-reset busy", 64'(busy_o), 64'(1));
        #2 reset = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        tick();
        reset = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_o) rose = 1'b1;
        end
        check("midreset valid never rose", 64'(rose), 64'(0));
        check_reset_values("post-release");

        // Normal operation resumes from the reset vector.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_and_check(vecs[0], "after_reset");
        ack_to_idle("after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
